apb_master_ctrl: RTL

//   APB master that drives the register-file APB slave.
//   - Accepts single read/write requests on a valid/ready host port.
//   - Runs each request as an APB SETUP/ACCESS transfer.
//   - Returns one response pulse per request with read data, slave error or timeout.
//   - Rejects out-of-range addresses locally, with no bus cycle.

---
 rtl/apb_master_ctrl_if.sv | 35 +++
 rtl/apb_master_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl_if.sv
// Host request/response port and APB bus of the APB master controller.
// The master modport is the controller's view; slave is the host/peripheral side.
interface apb_master_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        psel_m;
   logic        penable_m;
   logic        pwrite_m;
   logic [31:0] paddress_m;
   logic [31:0] pwdata_m;
   logic [31:0] prdata_m;
   logic        pready_m;
   logic        pslverr_m;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      input  prdata_m, pready_m, pslverr_m,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output psel_m, penable_m, pwrite_m, paddress_m, pwdata_m
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      output prdata_m, pready_m, pslverr_m,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  psel_m, penable_m, pwrite_m, paddress_m, pwdata_m
   );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB master: runs single host read/write requests as SETUP/ACCESS transfers,
// with local address range rejection and an optional PREADY timeout.
module apb_master_ctrl #(
   parameter int unsigned ADDR_LIMIT = 11,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic              pclk_m,
   input  logic              prst_m,
   apb_master_ctrl_if.master bus
);
   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W:0]   wait_inc;
   logic             psel_q, psel_d;
   logic             penable_q, penable_d;
   logic             pwrite_q, pwrite_d;
   logic [31:0]      paddr_q, paddr_d;
   logic [31:0]      pwdata_q, pwdata_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             go_idle;

   // NOTE: every signal gets a default before the case, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      go_idle       = 1'b0;
      wait_inc      = {1'b0, wait_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (bus.req_addr >= 32'(ADDR_LIMIT)) begin
                  rsp_valid_d   = 1'b1;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
                  rsp_rdata_d   = '0;
               end else begin
                  state_d    = SETUP;
                  wait_cnt_d = '0;
                  psel_d     = 1'b1;
                  penable_d  = 1'b0;
                  pwrite_d   = bus.req_write;
                  paddr_d    = bus.req_addr;
                  pwdata_d   = bus.req_write ? bus.req_wdata : '0;
               end
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (bus.pready_m) begin
               go_idle       = 1'b1;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = bus.pslverr_m;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = (!pwrite_q && !bus.pslverr_m) ? bus.prdata_m : '0;
            end else if (TIMEOUT != 0 && wait_inc >= (CNT_W + 1)'(TIMEOUT)) begin
               // The TIMEOUT-th consecutive wait cycle aborts the transfer.
               go_idle       = 1'b1;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end else if (!wait_inc[CNT_W]) begin
               wait_cnt_d = wait_inc[CNT_W-1:0];
            end
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (go_idle) begin
         state_d   = IDLE;
         psel_d    = 1'b0;
         penable_d = 1'b0;
         pwrite_d  = 1'b0;
         paddr_d   = '0;
         pwdata_d  = '0;
      end
   end

   // NOTE: non-blocking assignments so every flop updates from pre-edge values,
   // independent of statement order.
   always_ff @(posedge pclk_m) begin
      if (prst_m) begin
         state_q       <= IDLE;
         wait_cnt_q    <= '0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign bus.req_ready   = (state_q == IDLE);
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.psel_m      = psel_q;
   assign bus.penable_m   = penable_q;
   assign bus.pwrite_m    = pwrite_q;
   assign bus.paddress_m  = paddr_q;
   assign bus.pwdata_m    = pwdata_q;
endmodule
